// File: rtl/fuzz_pkg.sv
// Shared constants, state encoding and helper functions for the fuzz run sequencer.
// The LCG here must stay bit-identical to the one used by the bench flow.
package fuzz_pkg;

    localparam logic [31:0] LCG_MUL    = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC    = 32'h0000_3039;
    localparam int          FOLD_MAX_W = 1024;

    typedef logic [2:0] fsm_e;

    localparam fsm_e S_IDLE     = 3'd0;
    localparam fsm_e S_FILL     = 3'd1;
    localparam fsm_e S_APPLY    = 3'd2;
    localparam fsm_e S_SETTLE_W = 3'd3;
    localparam fsm_e S_CAPTURE  = 3'd4;
    localparam fsm_e S_DONE     = 3'd5;

    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * LCG_MUL + LCG_INC;
    endfunction

    // XOR of 32-bit chunks; bits at or above 'width' are masked off so the
    // last partial chunk behaves as if zero-extended.
    function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] data,
                                           input int width);
        logic [31:0] acc;
        logic [31:0] mask;
        acc = '0;
        for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
            if (width >= (i + 1) * 32)
                mask = '1;
            else if (width <= i * 32)
                mask = '0;
            else
                mask = (32'd1 << (width - i * 32)) - 32'd1;
            acc = acc ^ (data[i*32 +: 32] & mask);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fuzz_lcg32.sv
// 32-bit LCG state register: load a seed, or advance one step; q is the next value.
module fuzz_lcg32
    import fuzz_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] rng;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rng <= '0;
        else if (load)
            rng <= seed;
        else if (step)
            rng <= q;
    end

    assign q = lcg_next(rng);

endmodule

// File: rtl/fuzz_run_ctrl.sv
// Stimulus sequencer: fills a shadow vector from the LCG, applies it, waits for the
// DUT to settle and folds the response into a running signature.
module fuzz_run_ctrl
    import fuzz_pkg::*;
#(
    parameter int          IN_W     = 258,
    parameter int          OUT_W    = 330,
    parameter int          SETTLE   = 1,
    parameter logic [31:0] SIG_INIT = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [31:0]      num_vec,
    output logic             busy,
    output logic             done,
    output logic [IN_W-1:0]  stim_flat,
    output logic             stim_valid,
    input  logic [OUT_W-1:0] resp_flat,
    output logic [31:0]      signature,
    output logic [31:0]      vec_count
);

    localparam int NW     = (IN_W + 31) / 32;
    localparam int LAST_W = IN_W - 32 * (NW - 1);
    localparam int WI_W   = $clog2(NW + 1);

    fsm_e            state;
    logic [WI_W-1:0] w;
    logic [31:0]     settle_cnt;
    logic [31:0]     num_vec_q;
    logic [IN_W-1:0] shadow;
    logic [IN_W-1:0] shadow_next;
    logic [31:0]     rng_q;
    logic            accept;
    logic            fill_write;

    assign accept     = (state == S_IDLE) && start;
    assign fill_write = (state == S_FILL);

    fuzz_lcg32 u_lcg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (fill_write && !abort),
        .seed  (seed),
        .q     (rng_q)
    );

    genvar g;
    generate
        for (g = 0; g < NW; g++) begin : g_word
            if (g < NW - 1) begin : g_full
                assign shadow_next[g*32 +: 32] =
                    (fill_write && w == WI_W'(g)) ? rng_q : shadow[g*32 +: 32];
            end else begin : g_last
                assign shadow_next[IN_W-1:g*32] =
                    (fill_write && w == WI_W'(g)) ? rng_q[LAST_W-1:0] : shadow[IN_W-1:g*32];
            end
        end
    endgenerate

    // stim_flat is loaded on the edge that enters APPLY, so the vector is already
    // on the bus during the stim_valid cycle and the response sample lands SETTLE+1 later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            w          <= '0;
            settle_cnt <= '0;
            num_vec_q  <= '0;
            shadow     <= '0;
            stim_flat  <= '0;
            signature  <= '0;
            vec_count  <= '0;
        end else begin
            shadow <= shadow_next;
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            num_vec_q <= num_vec;
                            signature <= SIG_INIT;
                            vec_count <= '0;
                            w         <= '0;
                            state     <= (num_vec == '0) ? S_DONE : S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (w == WI_W'(NW - 1)) begin
                            stim_flat <= shadow_next;
                            state     <= S_APPLY;
                        end else begin
                            w <= w + 1'b1;
                        end
                    end
                    S_APPLY: begin
                        settle_cnt <= 32'(SETTLE - 1);
                        state      <= S_SETTLE_W;
                    end
                    S_SETTLE_W: begin
                        if (settle_cnt == '0)
                            state <= S_CAPTURE;
                        else
                            settle_cnt <= settle_cnt - 32'd1;
                    end
                    S_CAPTURE: begin
                        signature <= {signature[30:0], signature[31]}
                                     ^ fold32(FOLD_MAX_W'(resp_flat), OUT_W);
                        vec_count <= vec_count + 32'd1;
                        if (vec_count + 32'd1 == num_vec_q) begin
                            state <= S_DONE;
                        end else begin
                            w     <= '0;
                            state <= S_FILL;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign stim_valid = (state == S_APPLY);

endmodule

// File: tb/tb_fuzz_run_ctrl.sv
// Directed self-checking bench for fuzz_run_ctrl with a small LCG reference model.
module tb_fuzz_run_ctrl;

    localparam int IN_W  = 258;
    localparam int OUT_W = 330;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [31:0]      seed;
    logic [31:0]      num_vec;
    logic             busy;
    logic             done;
    logic [IN_W-1:0]  stim_flat;
    logic             stim_valid;
    logic [OUT_W-1:0] resp_flat;
    logic [31:0]      signature;
    logic [31:0]      vec_count;

    int errors;
    int checks;
    int sv_pulses;
    int done_pulses;

    fuzz_run_ctrl #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .SETTLE   (1),
        .SIG_INIT (32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .stim_flat  (stim_flat),
        .stim_valid (stim_valid),
        .resp_flat  (resp_flat),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stim_valid === 1'b1) sv_pulses++;
        if (done === 1'b1) done_pulses++;
    end

    function automatic logic [31:0] lcg(input logic [31:0] s);
        return s * 32'h41C6_4E6D + 32'h0000_3039;
    endfunction

    // Nine LCG steps from r_in, packed LSB-first and truncated to 258 bits.
    function automatic logic [IN_W-1:0] model_vec(input logic [31:0] r_in,
                                                  output logic [31:0] r_out);
        logic [287:0] t;
        logic [31:0]  r;
        r = r_in;
        for (int i = 0; i < 9; i++) begin
            r = lcg(r);
            t[i*32 +: 32] = r;
        end
        r_out = r;
        return t[IN_W-1:0];
    endfunction

    task automatic start_run(input logic [31:0] s, input logic [31:0] n);
        start   = 1'b1;
        seed    = s;
        num_vec = n;
        @(negedge clk);
        start   = 1'b0;
        seed    = '0;
        num_vec = '0;
    endtask

    // Advances negedge by negedge until stim_valid (which=0) or done (which=1) is seen.
    task automatic wait_event(input bit which, input int limit,
                              output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        while (cycles < limit) begin
            if ((which ? done : stim_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; num_vec = '0; resp_flat = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (stim_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_stim_valid: got %b expected 0", stim_valid); end
        checks++; if (stim_flat !== '0) begin errors++; $display("[TB] FAIL reset_stim_flat: got %h expected 0", stim_flat); end
        checks++; if (signature !== 32'h0) begin errors++; $display("[TB] FAIL reset_signature: got %h expected 00000000", signature); end
        checks++; if (vec_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_vec_count: got %h expected 0", vec_count); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_vector();
        int k; bit ok; int sv0; int dn0;
        logic [31:0] r; logic [IN_W-1:0] exp_v;
        exp_v = model_vec(32'd0, r);
        resp_flat = '0;
        sv0 = sv_pulses; dn0 = done_pulses;
        start_run(32'd0, 32'd1);
        wait_event(1'b0, 40, k, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_stim_timeout: got none expected stim_valid"); end
        checks++; if (k != 9) begin errors++; $display("[TB] FAIL single_fill_len: got %0d expected 9", k); end
        checks++; if (stim_flat[31:0] !== 32'h0000_3039) begin errors++; $display("[TB] FAIL single_word0: got %h expected 00003039", stim_flat[31:0]); end
        checks++; if (stim_flat[63:32] !== 32'hD3DC_167E) begin errors++; $display("[TB] FAIL single_word1: got %h expected d3dc167e", stim_flat[63:32]); end
        checks++; if (stim_flat !== exp_v) begin errors++; $display("[TB] FAIL single_vector: got %h expected %h", stim_flat, exp_v); end
        checks++; if (stim_flat[257:256] !== r[1:0]) begin errors++; $display("[TB] FAIL single_top_bits: got %b expected %b", stim_flat[257:256], r[1:0]); end
        wait_event(1'b1, 20, k, ok);
        checks++; if (!ok || k != 3) begin errors++; $display("[TB] FAIL single_done_delay: got %0d expected 3", k); end
        checks++; if (vec_count !== 32'd1) begin errors++; $display("[TB] FAIL single_vec_count: got %0d expected 1", vec_count); end
        checks++; if (signature !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL single_signature: got %h expected ffffffff", signature); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL single_after_done: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (sv_pulses - sv0 != 1) begin errors++; $display("[TB] FAIL single_sv_pulses: got %0d expected 1", sv_pulses - sv0); end
        checks++; if (done_pulses - dn0 != 1) begin errors++; $display("[TB] FAIL single_done_pulses: got %0d expected 1", done_pulses - dn0); end
    endtask

    task automatic test_zero_vectors();
        int sv0;
        sv0 = sv_pulses;
        start_run(32'h1234_5678, 32'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_done_busy: got done=%b busy=%b expected 1 1", done, busy); end
        checks++; if (signature !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL zero_signature: got %h expected ffffffff", signature); end
        checks++; if (vec_count !== 32'd0) begin errors++; $display("[TB] FAIL zero_vec_count: got %0d expected 0", vec_count); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy); end
        repeat (3) @(negedge clk);
        checks++; if (sv_pulses != sv0) begin errors++; $display("[TB] FAIL zero_no_stim: got %0d pulses expected 0", sv_pulses - sv0); end
    endtask

    task automatic test_back_to_back();
        int k; bit ok; logic [31:0] r; logic [31:0] w8;
        logic [IN_W-1:0] ev [3];
        resp_flat = '0;
        r = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) ev[i] = model_vec(r, r);
        w8 = lcg(lcg(lcg(lcg(lcg(lcg(lcg(lcg(lcg(32'hCAFE_0001)))))))));
        start_run(32'hCAFE_0001, 32'd3);
        for (int i = 0; i < 3; i++) begin
            wait_event(1'b0, 40, k, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_stim_timeout_%0d: got none expected stim_valid", i); end
            if (i > 0) begin
                checks++; if (k + 1 != 12) begin errors++; $display("[TB] FAIL b2b_gap_%0d: got %0d expected 12", i, k + 1); end
            end
            checks++; if (stim_flat !== ev[i]) begin errors++; $display("[TB] FAIL b2b_vector_%0d: got %h expected %h", i, stim_flat, ev[i]); end
            if (i == 1) begin
                checks++; if (stim_flat[31:0] !== lcg(w8)) begin errors++; $display("[TB] FAIL b2b_continue: got %h expected %h", stim_flat[31:0], lcg(w8)); end
            end
            @(negedge clk);
        end
        wait_event(1'b1, 20, k, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_done_timeout: got none expected done"); end
        checks++; if (signature !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_signature: got %h expected ffffffff", signature); end
        checks++; if (vec_count !== 32'd3) begin errors++; $display("[TB] FAIL b2b_vec_count: got %0d expected 3", vec_count); end
        @(negedge clk);
    endtask

    task automatic test_fold();
        int k; bit ok;
        resp_flat = '0;
        resp_flat[0] = 1'b1;
        start_run(32'd99, 32'd1);
        wait_event(1'b1, 40, k, ok);
        checks++; if (!ok || signature !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL fold_one: got %h expected fffffffe", signature); end
        @(negedge clk);
        resp_flat[329] = 1'b1;
        start_run(32'd99, 32'd1);
        wait_event(1'b1, 40, k, ok);
        checks++; if (!ok || signature !== 32'hFFFF_FDFE) begin errors++; $display("[TB] FAIL fold_last_chunk: got %h expected fffffdfe", signature); end
        @(negedge clk);
        resp_flat = '0;
    endtask

    task automatic test_abort();
        int k; bit ok; int dn0; logic [31:0] r; logic [IN_W-1:0] v1; logic [IN_W-1:0] v2; logic [IN_W-1:0] v0;
        resp_flat = '0;
        v1 = model_vec(32'd7, r);
        v2 = model_vec(r, r);
        v0 = model_vec(32'd0, r);
        start_run(32'd7, 32'd5);
        start_run(32'h0000_1234, 32'd1);
        wait_event(1'b0, 40, k, ok);
        checks++; if (!ok || stim_flat !== v1) begin errors++; $display("[TB] FAIL abort_vec1: got %h expected %h", stim_flat, v1); end
        @(negedge clk);
        wait_event(1'b0, 40, k, ok);
        checks++; if (!ok || stim_flat !== v2) begin errors++; $display("[TB] FAIL abort_vec2: got %h expected %h", stim_flat, v2); end
        dn0 = done_pulses;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (vec_count !== 32'd1) begin errors++; $display("[TB] FAIL abort_vec_count: got %0d expected 1", vec_count); end
        checks++; if (stim_flat !== v2) begin errors++; $display("[TB] FAIL abort_stim_hold: got %h expected %h", stim_flat, v2); end
        repeat (2) @(negedge clk);
        checks++; if (done_pulses != dn0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_pulses - dn0); end
        start_run(32'd0, 32'd1);
        wait_event(1'b0, 40, k, ok);
        checks++; if (!ok || stim_flat !== v0) begin errors++; $display("[TB] FAIL abort_restart: got %h expected %h", stim_flat, v0); end
        wait_event(1'b1, 20, k, ok);
        checks++; if (!ok || vec_count !== 32'd1) begin errors++; $display("[TB] FAIL abort_restart_done: got %0d expected 1", vec_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int k; bit ok; logic [31:0] r; logic [IN_W-1:0] v2;
        v2 = model_vec(32'h55, r);
        v2 = model_vec(r, r);
        resp_flat = '0;
        resp_flat[31:0]    = 32'h1234_5678;
        resp_flat[329:320] = 10'h3A5;
        start_run(32'h55, 32'd2);
        wait_event(1'b0, 40, k, ok);
        repeat (5) @(negedge clk);
        checks++; if (!ok || signature !== 32'hEDCB_AA22) begin errors++; $display("[TB] FAIL midrun_sig1: got %h expected edcbaa22", signature); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || signature !== 32'h0 || vec_count !== 32'h0 || stim_flat !== '0)
            begin errors++; $display("[TB] FAIL midrun_async_reset: got busy=%b sig=%h cnt=%0d expected all zero", busy, signature, vec_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(32'h55, 32'd2);
        wait_event(1'b0, 40, k, ok);
        @(negedge clk);
        wait_event(1'b0, 40, k, ok);
        checks++; if (!ok || stim_flat !== v2) begin errors++; $display("[TB] FAIL midrun_rerun_vec: got %h expected %h", stim_flat, v2); end
        wait_event(1'b1, 20, k, ok);
        checks++; if (!ok || signature !== 32'hC9A3_0198) begin errors++; $display("[TB] FAIL midrun_rerun_sig: got %h expected c9a30198", signature); end
        @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0; sv_pulses = 0; done_pulses = 0;
        test_reset();
        test_single_vector();
        test_zero_vectors();
        test_back_to_back();
        test_fold();
        test_abort();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
